store_buffer_unit: RTL and testbench
====================================

# store_buffer_unit

Parametrised store path between the LSU and the Wishbone data bus. It accepts store requests (byte/half/word/double) through a valid/ready handshake and queues them in a DEPTH-entry FIFO. A drain state machine encodes each entry into lane-shifted data plus byte selects and issues Wishbone classic write cycles. Compared with the single-cycle encoder, it adds a parametrised bus width, buffering, bus-error reporting and optional splitting of word-crossing stores into two beats.

## Interface
- DATA_W, 32: bus data width in bits, 32 or 64; NB = DATA_W/8 lanes, OW = log2(NB).
- DEPTH, 4: FIFO entries, power of two, at least 2.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  FIFO not full; equals !full, combinational.
- req_type  in  2  0=B, 1=H, 2=W, 3=D; D is reserved when DATA_W=32.
- req_addr  in  32  byte address.
- req_data  in  DATA_W  store data, right-justified.
- wb_cyc, wb_stb, wb_we  out  1  Wishbone classic controls; all three are driven identically.
- wb_adr  out  32  NB-aligned address, low OW bits are 0.
- wb_dat_o  out  DATA_W  lane-shifted data; unselected lanes are 0.
- wb_sel  out  NB  byte lane enables.
- wb_ack, wb_err  in  1  cycle termination.
- misaligned_exception  out  1  one-cycle pulse.
- bus_error  out  1  one-cycle pulse.
- idle  out  1  FIFO empty and FSM in IDLE; used for fence/drain.

## Operation
- **Acceptance:** a request is accepted when req_valid && req_ready.
  - off = req_addr[OW-1:0]; bytes = 1/2/4/8 by type.
- **In-word store** (off+bytes <= NB): enqueued as a single-beat entry.
  - sel = ((1<<bytes)-1) << off; data = req_data[8*bytes-1:0] << 8*off.
- **Word-crossing store** (off+bytes > NB): handling is set under Configuration.
- **Reserved type** (type 3 with DATA_W=32): accepted and discarded. No enqueue, no exception.
- **FIFO:** stores encoded beat0/beat1 data, sel, address and a split flag. Count width is log2(DEPTH)+1.
- **Drain FSM** states: IDLE, BEAT0, BEAT1.
  - IDLE -> BEAT0 when the FIFO is non-empty; the head is loaded into output registers.
  - BEAT0 + ack: if split -> BEAT1, else pop the entry and go to IDLE.
  - BEAT1 + ack: pop the entry, go to IDLE.
  - err in BEAT0 or BEAT1: pulse bus_error, pop the entry (any remaining beat is dropped), go to IDLE.
- wb_cyc/stb/we are asserted only in BEAT0/BEAT1. All outputs are held stable until ack or err.
- If ack and err are both high, err wins.

## Timing
- **Reset (rst_n low, async):** FIFO empty; FSM IDLE.
  - wb_cyc/stb/we = 0, wb_adr = 0, wb_dat_o = 0, wb_sel = 0.
  - misaligned_exception = 0, bus_error = 0, idle = 1, req_ready = 1.
- **Reset mid-transaction:** drops the cycle and every queued entry immediately; no pulses are generated.
- **Latency:** a request accepted at edge N drives wb_stb from edge N+1 (IDLE->BEAT0 at edge N+1 when the FIFO was empty).
- **Pop and next head:** the entry is popped at the ack edge. The FSM spends one IDLE cycle before the next head, so wb_cyc drops for at least one cycle between stores.
- **Split stores:** BEAT1 is asserted in the cycle after the beat0 ack. wb_cyc stays high across the beats; only stb sequencing matters.
- **Full FIFO:** req_ready = 0. A pop in the same cycle does not raise req_ready until the next cycle (no bypass).
- **misaligned_exception:** pulses in the cycle after the offending acceptance.
- **bus_error:** pulses in the cycle after the err edge.
- idle is registered-state derived, with no combinational path from req_valid.

## Configuration
- Macro: STORE_BUFFER_UNIT_SPLIT_EN.
- **Defined:** a word-crossing store is enqueued as a split entry.
  - Beat0: wb_adr = addr & ~(NB-1); sel = all lanes from off to NB-1; data = low (NB-off) bytes shifted to off.
  - Beat1: wb_adr = beat0 address + NB; sel = (1<<(off+bytes-NB))-1; data = remaining high bytes at lane 0.
  - No exception is raised.
- **Undefined:** a word-crossing store is accepted, not enqueued, and pulses misaligned_exception. BEAT1 logic is compiled out.

## Test plan
- **Byte store:** DATA_W=32, SB to addr 0x1003, data 0xAB, ack after 2 cycles.
  - Required: wb_adr=0x1000, wb_sel=0b1000, wb_dat_o=0xAB000000, single cycle, idle returns to 1.
- **Unaligned halfword within a word:** SH to addr 0x2001, data 0x1234.
  - Required: wb_sel=0b0110, wb_dat_o=0x00123400, no exception.
- **Word-crossing SW:** SW to 0x3003, data 0xDDCCBBAA.
  - With the macro: beat0 adr 0x3000, sel 0b1000, dat 0xAA000000; then beat1 adr 0x3004, sel 0b0111, dat 0x00DDCCBB.
  - Without the macro: misaligned_exception pulses once, no wb_cyc.
- **Back-pressure:** DEPTH=4, wb_ack held low, issue 5 stores.
  - Required: req_ready drops after the 4th acceptance; all 5 complete in order once ack resumes.
- **Bus error:** wb_err on a split beat0.
  - Required: bus_error pulses once, beat1 is not issued, the next queued store proceeds.
- **64-bit store:** DATA_W=64, SD to 0x8, then async reset asserted mid-cycle.
  - Required: sel=0xFF with full data; on reset, wb_cyc=0 immediately and idle=1.

Source files
------------

// File: rtl/store_buffer_unit.sv
// -----------------------------------------------------------------------------
// store_buffer_unit
//
// Buffered store path from the LSU to a Wishbone classic data bus. Store
// requests are encoded on acceptance (lane shift + byte selects) and queued
// in a DEPTH-entry FIFO. A drain FSM (IDLE/BEAT0/BEAT1) pops the head and
// issues one or two Wishbone write beats per entry.
//
// Optional feature macro: STORE_BUFFER_UNIT_SPLIT_EN
//   defined   : word-crossing stores become a two-beat (split) entry
//   undefined : word-crossing stores are dropped and pulse
//               misaligned_exception; the BEAT1 path is compiled out
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// are both high; req_ready is simply "FIFO not full" from registered state,
// so it never depends on req_valid and a same-cycle pop does not raise it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   store request handshake
//   req_type              0=B 1=H 2=W 3=D (D reserved when DATA_W=32)
//   req_addr, req_data    byte address, right-justified store data
//   wb_cyc/stb/we         Wishbone controls (identical)
//   wb_adr/dat_o/sel      aligned address, lane-shifted data, byte selects
//   wb_ack, wb_err        cycle termination (err wins)
//   misaligned_exception  one-cycle pulse after a dropped crossing store
//   bus_error             one-cycle pulse after an err termination
//   idle                  FIFO empty and FSM in IDLE
//   dbg_state             drain FSM state (0=IDLE 1=BEAT0 2=BEAT1)
// -----------------------------------------------------------------------------
module store_buffer_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_type,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  output logic [31:0]         wb_adr,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel,
  input  logic                wb_ack,
  input  logic                wb_err,
  output logic                misaligned_exception,
  output logic                bus_error,
  output logic                idle,
  output logic [1:0]          dbg_state
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0]  NB32     = 32'(NB);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_e;

`ifdef STORE_BUFFER_UNIT_SPLIT_EN
  typedef struct packed {
    logic [31:0]       addr;
    logic [NB-1:0]     sel0;
    logic [DATA_W-1:0] dat0;
    logic [NB-1:0]     sel1;
    logic [DATA_W-1:0] dat1;
    logic              split;
  } entry_t;
`else
  typedef struct packed {
    logic [31:0]       addr;
    logic [NB-1:0]     sel0;
    logic [DATA_W-1:0] dat0;
  } entry_t;
`endif

  // ---------------------------------------------------------------------------
  // Request encoding
  // ---------------------------------------------------------------------------
  logic [OW-1:0]     off;
  logic [3:0]        nbytes;
  logic [4:0]        end_lane;
  logic              reserved;
  logic              crossing;
  logic              accept;
  logic              push;
  logic              mis_d;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] data_masked;
  entry_t            wr_entry;

  always_comb begin
    off       = req_addr[OW-1:0];
    nbytes    = 4'd1 << req_type;
    end_lane  = 5'(off) + 5'(nbytes);
    reserved  = (DATA_W == 32) && (req_type == 2'd3);
    crossing  = end_lane > 5'(NB);
    accept    = req_valid && req_ready;
    lane_mask   = '0;
    data_masked = '0;
    // Keep only the bytes that belong to this store size.
    for (int i = 0; i < NB; i++) begin
      lane_mask[i]          = (i < int'(nbytes));
      data_masked[8*i +: 8] = lane_mask[i] ? req_data[8*i +: 8] : 8'h00;
    end
  end

`ifdef STORE_BUFFER_UNIT_SPLIT_EN
  // Shift into a double-width window: the low half is beat0, the high half
  // is whatever spilled over into the next bus word (beat1).
  logic [2*DATA_W-1:0] wide_dat;
  logic [2*NB-1:0]     wide_sel;

  assign wide_dat = {{DATA_W{1'b0}}, data_masked} << {off, 3'b000};
  assign wide_sel = {{NB{1'b0}}, lane_mask} << off;
  assign push     = accept && !reserved;
  assign mis_d    = 1'b0;

  always_comb begin
    wr_entry.addr  = {req_addr[31:OW], {OW{1'b0}}};
    wr_entry.sel0  = wide_sel[NB-1:0];
    wr_entry.dat0  = wide_dat[DATA_W-1:0];
    wr_entry.sel1  = wide_sel[2*NB-1:NB];
    wr_entry.dat1  = wide_dat[2*DATA_W-1:DATA_W];
    wr_entry.split = crossing;
  end
`else
  assign push  = accept && !reserved && !crossing;
  assign mis_d = accept && !reserved && crossing;

  always_comb begin
    wr_entry.addr = {req_addr[31:OW], {OW{1'b0}}};
    wr_entry.sel0 = lane_mask << off;
    wr_entry.dat0 = data_masked << {off, 3'b000};
  end
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop;

  assign head      = mem_q[rd_ptr_q];
  assign req_ready = (count_q != FULL_CNT);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [NB-1:0]     sel_q, sel_d;
  logic              berr_d;
  logic              mis_q, berr_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    pop     = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_BEAT0;
          adr_d   = head.addr;
          dat_d   = head.dat0;
          sel_d   = head.sel0;
        end
      end
      S_BEAT0: begin
        if (wb_err) begin
          // Error ends the whole entry, including any pending second beat.
          berr_d  = 1'b1;
          pop     = 1'b1;
          state_d = S_IDLE;
        end
`ifdef STORE_BUFFER_UNIT_SPLIT_EN
        else if (wb_ack && head.split) begin
          state_d = S_BEAT1;
          adr_d   = adr_q + NB32;
          dat_d   = head.dat1;
          sel_d   = head.sel1;
        end
`endif
        else if (wb_ack) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BEAT1: begin
`ifdef STORE_BUFFER_UNIT_SPLIT_EN
        if (wb_err || wb_ack) begin
          berr_d  = wb_err;
          pop     = 1'b1;
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Bus outputs read as zero whenever no cycle is in progress.
    if (state_d == S_IDLE) begin
      adr_d = '0;
      dat_d = '0;
      sel_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign wb_cyc               = (state_q != S_IDLE);
  assign wb_stb               = wb_cyc;
  assign wb_we                = wb_cyc;
  assign wb_adr               = adr_q;
  assign wb_dat_o             = dat_q;
  assign wb_sel               = sel_q;
  assign misaligned_exception = mis_q;
  assign bus_error            = berr_q;
  assign idle                 = (count_q == '0) && (state_q == S_IDLE);
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_store_buffer_unit.sv
module tb_store_buffer_unit;

  localparam int BW = 68; // {adr[31:0], sel[3:0], dat[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst64_n;

  // ---------------- 32-bit DUT ----------------
  logic        req_valid, req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_addr, req_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic        mis, berr, idle;
  logic [1:0]  dbg_state;

  store_buffer_unit #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
    .misaligned_exception(mis), .bus_error(berr), .idle(idle),
    .dbg_state(dbg_state)
  );

  // ---------------- 64-bit DUT ----------------
  logic        r64_valid, r64_ready;
  logic [1:0]  r64_type;
  logic [31:0] r64_addr;
  logic [63:0] r64_data;
  logic        cyc64, stb64, we64;
  logic [31:0] adr64;
  logic [63:0] dat64;
  logic [7:0]  sel64;
  logic        ack64, err64, mis64, berr64, idle64;
  logic [1:0]  dbg64;

  store_buffer_unit #(.DATA_W(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst64_n),
    .req_valid(r64_valid), .req_ready(r64_ready), .req_type(r64_type),
    .req_addr(r64_addr), .req_data(r64_data),
    .wb_cyc(cyc64), .wb_stb(stb64), .wb_we(we64), .wb_adr(adr64),
    .wb_dat_o(dat64), .wb_sel(sel64), .wb_ack(ack64), .wb_err(err64),
    .misaligned_exception(mis64), .bus_error(berr64), .idle(idle64),
    .dbg_state(dbg64)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int mis_cnt = 0;
  int berr_cnt = 0;
  int exp_mis = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];

  // Pulse counters for the exception / error outputs.
  initial forever begin
    @(negedge clk);
    if (mis === 1'b1) mis_cnt++;
    if (berr === 1'b1) berr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Places every byte of the store at its own byte address, then groups the
  // bytes by bus word. One word = one beat; two words = a crossing store.
  function automatic void model_store(input logic [1:0] t, input logic [31:0] a,
                                      input logic [31:0] d);
    logic [31:0] wa [2];
    logic [3:0]  sl [2];
    logic [31:0] dt [2];
    logic [31:0] ba;
    int nb, idx, lane, nbytes;
    if (t == 2'd3) return; // reserved on a 32-bit bus: silently dropped
    nbytes = 1 << t;
    nb = 0;
    for (int j = 0; j < 2; j++) begin wa[j] = '0; sl[j] = '0; dt[j] = '0; end
    for (int k = 0; k < nbytes; k++) begin
      ba   = a + 32'(k);
      idx  = ((ba & ~32'd3) == (a & ~32'd3)) ? 0 : 1;
      lane = int'(ba[1:0]);
      if (idx + 1 > nb) nb = idx + 1;
      wa[idx]             = ba & ~32'd3;
      sl[idx][lane]       = 1'b1;
      dt[idx][8*lane +: 8] = d[8*k +: 8];
    end
    if (nb == 1) exp_q.push_back({wa[0], sl[0], dt[0]});
    else begin
`ifdef STORE_BUFFER_UNIT_SPLIT_EN
      exp_q.push_back({wa[0], sl[0], dt[0]});
      exp_q.push_back({wa[1], sl[1], dt[1]});
`else
      exp_mis++;
`endif
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = 0;
    req_valid = 1'b1; req_type = t; req_addr = a; req_data = d;
    while (req_ready !== 1'b1 && b < 300) begin @(negedge clk); b++; end
    n_cmp++;
    if (b >= 300) begin
      n_fail++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", req_ready, b);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wishbone responder: random wait states, records every terminated beat.
  task automatic drain(input int n, input bit err_first);
    int cyc_n, wait_n;
    bit first;
    cyc_n = 0;
    first = err_first;
    wait_n = $urandom_range(0, 2);
    while (obs_q.size() < n && cyc_n < 2000) begin
      @(negedge clk);
      cyc_n++;
      wb_ack = 1'b0; wb_err = 1'b0;
      if (wb_stb === 1'b1) begin
        if (wait_n == 0) begin
          obs_q.push_back({wb_adr, wb_sel, wb_dat_o});
          if (first) begin wb_err = 1'b1; first = 1'b0; end
          else wb_ack = 1'b1;
          wait_n = $urandom_range(0, 2);
        end else wait_n--;
      end
    end
    @(negedge clk);
    wb_ack = 1'b0; wb_err = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 000", {wb_cyc, wb_stb, wb_we});
    end
    n_cmp++;
    if ({wb_adr, wb_dat_o, wb_sel} !== 68'h0) begin
      n_fail++; $display("FAIL reset_bus: adr=%h dat=%h sel=%h, required zeros", wb_adr, wb_dat_o, wb_sel);
    end
    n_cmp++;
    if ({mis, berr, idle, req_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL reset_status: mis/berr/idle/ready=%b, required 0011", {mis, berr, idle, req_ready});
    end
    n_cmp++;
    if ({cyc64, sel64, idle64, r64_ready} !== 11'b0_00000000_1_1) begin
      n_fail++; $display("FAIL reset_64: cyc=%b sel=%h idle=%b ready=%b, required 0 00 1 1", cyc64, sel64, idle64, r64_ready);
    end
  endtask

  task automatic test_byte_store;
    send(2'd0, 32'h1003, 32'h0000_00AB);
    n_cmp++;
    if ({wb_stb, idle} !== 2'b00) begin
      n_fail++; $display("FAIL byte_latency: stb/idle=%b one cycle after accept, required 00", {wb_stb, idle});
    end
    @(negedge clk);
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o} !== {3'b111, 32'h1000, 4'b1000, 32'hAB00_0000}) begin
      n_fail++; $display("FAIL byte_beat: ctrl=%b adr=%h sel=%b dat=%h, required 111 00001000 1000 ab000000",
                         {wb_cyc, wb_stb, wb_we}, wb_adr, wb_sel, wb_dat_o);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wb_stb, wb_adr, wb_sel, wb_dat_o} !== {1'b1, 32'h1000, 4'b1000, 32'hAB00_0000}) begin
      n_fail++; $display("FAIL byte_hold: stb=%b adr=%h sel=%b dat=%h, required held beat", wb_stb, wb_adr, wb_sel, wb_dat_o);
    end
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    n_cmp++;
    if ({wb_cyc, idle, wb_sel} !== 6'b0_1_0000) begin
      n_fail++; $display("FAIL byte_done: cyc=%b idle=%b sel=%b, required 0 1 0000", wb_cyc, idle, wb_sel);
    end
  endtask

  task automatic test_half_store;
    int m0;
    m0 = mis_cnt;
    obs_q.delete();
    send(2'd1, 32'h2001, 32'h0000_1234);
    drain(1, 1'b0);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== {32'h2000, 4'b0110, 32'h0012_3400}) begin
      n_fail++; $display("FAIL half_beat: got %0d beats first=%h, required 1 beat %h",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, {32'h2000, 4'b0110, 32'h0012_3400});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mis_cnt != m0) begin
      n_fail++; $display("FAIL half_exc: %0d exception pulses, required 0", mis_cnt - m0);
    end
  endtask

  task automatic test_cross_word;
    int m0;
    m0 = mis_cnt;
    obs_q.delete();
    send(2'd2, 32'h3003, 32'hDDCC_BBAA);
`ifdef STORE_BUFFER_UNIT_SPLIT_EN
    drain(2, 1'b0);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL cross_count: got %0d beats, required 2", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== {32'h3000, 4'b1000, 32'hAA00_0000}) begin
        n_fail++; $display("FAIL cross_beat0: got %h, required %h", obs_q[0], {32'h3000, 4'b1000, 32'hAA00_0000});
      end
      n_cmp++;
      if (obs_q[1] !== {32'h3004, 4'b0111, 32'h00DD_CCBB}) begin
        n_fail++; $display("FAIL cross_beat1: got %h, required %h", obs_q[1], {32'h3004, 4'b0111, 32'h00DD_CCBB});
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mis_cnt != m0) begin
      n_fail++; $display("FAIL cross_exc: %0d exception pulses, required 0", mis_cnt - m0);
    end
`else
    n_cmp++;
    if (mis !== 1'b1) begin
      n_fail++; $display("FAIL cross_pulse: misaligned_exception=%b after accept, required 1", mis);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mis, wb_cyc, idle} !== 3'b001) begin
        n_fail++; $display("FAIL cross_quiet: mis/cyc/idle=%b at cycle %0d, required 001", {mis, wb_cyc, idle}, i);
      end
    end
`endif
  endtask

  task automatic test_back_pressure;
    logic [31:0] d;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      model_store(2'd2, 32'h0000_4000 + 32'(i * 4), d);
      send(2'd2, 32'h0000_4000 + 32'(i * 4), d);
      if (i == 2) begin
        n_cmp++;
        if (req_ready !== 1'b1) begin
          n_fail++; $display("FAIL bp_ready3: req_ready=%b after 3 accepts, required 1", req_ready);
        end
      end
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: req_ready=%b after 4 accepts, required 0", req_ready);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, wb_stb} !== 2'b01) begin
      n_fail++; $display("FAIL bp_hold: ready/stb=%b while ack low, required 01", {req_ready, wb_stb});
    end
    d = $urandom();
    model_store(2'd2, 32'h0000_4010, d);
    fork
      send(2'd2, 32'h0000_4010, d);
      drain(5, 1'b0);
    join
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_order beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bus_error;
    int b0;
    logic [31:0] da, db, aa;
    exp_q.delete(); obs_q.delete();
    b0 = berr_cnt;
    da = $urandom(); db = $urandom();
`ifdef STORE_BUFFER_UNIT_SPLIT_EN
    aa = 32'h0000_6003;
`else
    aa = 32'h0000_6000;
`endif
    model_store(2'd2, aa, da);
`ifdef STORE_BUFFER_UNIT_SPLIT_EN
    exp_q.delete(1); // err on beat0 drops the second beat
`endif
    model_store(2'd2, 32'h0000_7000, db);
    send(2'd2, aa, da);
    send(2'd2, 32'h0000_7000, db);
    drain(exp_q.size(), 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (berr_cnt - b0 != 1) begin
      n_fail++; $display("FAIL berr_pulse: %0d bus_error pulses, required 1", berr_cnt - b0);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL berr_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL berr_seq beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({idle, wb_cyc} !== 2'b10) begin
      n_fail++; $display("FAIL berr_idle: idle/cyc=%b, required 10", {idle, wb_cyc});
    end
  endtask

  task automatic test_random;
    logic [1:0]  ta [30];
    logic [31:0] aa [30];
    logic [31:0] dd [30];
    int m0;
    exp_q.delete(); obs_q.delete();
    exp_mis = 0;
    m0 = mis_cnt;
    for (int i = 0; i < 30; i++) begin
      ta[i] = 2'($urandom_range(0, 3));
      aa[i] = $urandom();
      dd[i] = $urandom();
      model_store(ta[i], aa[i], dd[i]);
    end
    fork
      begin
        for (int i = 0; i < 30; i++) send(ta[i], aa[i], dd[i]);
      end
      drain(exp_q.size(), 1'b0);
    join
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (mis_cnt - m0 != exp_mis) begin
      n_fail++; $display("FAIL rand_exc: %0d exception pulses, required %0d", mis_cnt - m0, exp_mis);
    end
    n_cmp++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL rand_idle: idle=%b after drain, required 1", idle);
    end
  endtask

  task automatic test_64bit_reset;
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    r64_valid = 1'b1; r64_type = 2'd3; r64_addr = 32'h0000_0008; r64_data = d;
    @(negedge clk);
    r64_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({stb64, adr64, sel64, dat64} !== {1'b1, 32'h0000_0008, 8'hFF, d}) begin
      n_fail++; $display("FAIL sd_beat: stb=%b adr=%h sel=%h dat=%h, required 1 00000008 ff %h", stb64, adr64, sel64, dat64, d);
    end
    #2 rst64_n = 1'b0;
    #1;
    n_cmp++;
    if ({cyc64, idle64, sel64, mis64, berr64} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sd_reset: cyc=%b idle=%b sel=%h mis=%b berr=%b, required 0 1 00 0 0", cyc64, idle64, sel64, mis64, berr64);
    end
    @(negedge clk);
    rst64_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cyc64, idle64, r64_ready} !== 3'b011) begin
      n_fail++; $display("FAIL sd_after: cyc/idle/ready=%b, required 011 (queue dropped)", {cyc64, idle64, r64_ready});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; rst64_n = 1'b0;
    req_valid = 1'b0; req_type = 2'd0; req_addr = '0; req_data = '0;
    wb_ack = 1'b0; wb_err = 1'b0;
    r64_valid = 1'b0; r64_type = 2'd0; r64_addr = '0; r64_data = '0;
    ack64 = 1'b0; err64 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1; rst64_n = 1'b1;
    @(negedge clk);
    test_byte_store;
    test_half_store;
    test_cross_word;
    test_back_pressure;
    test_bus_error;
    test_random;
    test_64bit_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
